// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocate at tail, out-of-order CDB writeback, commit from head.
// Optional mispredict squash port enabled with `define ROB_FLUSH_EN.
module reorder_buffer #(
    parameter int DEPTH = 8,
    parameter int DW    = 16,
    parameter int RW    = 4,
    parameter int TW    = $clog2(DEPTH)
) (
    input  logic          clk1,
    input  logic          rst,
`ifdef ROB_FLUSH_EN
    input  logic          flush,
`endif
    input  logic          alloc_valid,
    input  logic [RW-1:0] alloc_dest,
    output logic          alloc_ready,
    output logic [TW-1:0] alloc_tag,
    input  logic          wb_valid,
    input  logic [TW-1:0] wb_tag,
    input  logic [DW-1:0] wb_data,
    output logic          commit_valid,
    output logic [RW-1:0] commit_dest,
    output logic [DW-1:0] commit_data,
    input  logic          commit_ready,
    output logic [TW:0]   count,
    output logic          full,
    output logic          empty
);

    logic [DEPTH-1:0] busy_q, done_q;
    logic [RW-1:0]    dest_q [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [TW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [TW:0]      count_q, count_d;
    logic             clear, do_alloc, do_wb, do_commit;

`ifdef ROB_FLUSH_EN
    assign clear = rst | flush;
`else
    assign clear = rst;
`endif

    // Readiness comes from registered count only, so a same-cycle commit never frees a full buffer.
    assign full        = (count_q == (TW+1)'(DEPTH));
    assign empty       = (count_q == '0);
    assign alloc_ready = ~full;
    assign alloc_tag   = tail_q;
    assign count       = count_q;

    assign do_alloc     = alloc_valid & alloc_ready;
    assign do_wb        = wb_valid & busy_q[wb_tag];
    assign commit_valid = busy_q[head_q] & done_q[head_q];
    assign commit_dest  = commit_valid ? dest_q[head_q] : '0;
    assign commit_data  = commit_valid ? data_q[head_q] : '0;
    assign do_commit    = commit_valid & commit_ready;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (do_commit) head_d = head_q + 1'b1;
        if (do_alloc)  tail_d = tail_q + 1'b1;
        case ({do_alloc, do_commit})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk1) begin
        if (clear) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            busy_q  <= '0;
            done_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dest_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (do_alloc) begin
                busy_q[tail_q] <= 1'b1;
                done_q[tail_q] <= 1'b0;
                dest_q[tail_q] <= alloc_dest;
            end
            if (do_wb) begin
                done_q[wb_tag] <= 1'b1;
                data_q[wb_tag] <= wb_data;
            end
            // Commit clears last; the head is done, so it cannot also be the alloc slot.
            if (do_commit) begin
                busy_q[head_q] <= 1'b0;
                done_q[head_q] <= 1'b0;
            end
        end
    end

endmodule
